// File: rtl/my_input_reader_pkg.sv
// Shared constants for the switch/button input reader.
// Register select encodings and default sizes.
package my_input_reader_pkg;

    localparam int DEF_TICK_W = 20;
    localparam int DEF_SW_N   = 24;
    localparam int DEF_BTN_N  = 5;

    typedef enum logic [1:0] {
        SEL_SW  = 2'd0,
        SEL_BTN = 2'd1,
        SEL_EVT = 2'd2,
        SEL_RSV = 2'd3
    } sel_e;

endpackage

// File: rtl/my_input_reader_debounce.sv
// Two-flop synchroniser plus two-sample debounce.
// One instance per input bank; tick is shared.
module my_debounce #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] prev;
    logic [N-1:0] same;

    assign same = ~(s2 ^ prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
            dout <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (tick) begin
                prev <= s2;
                // accept only samples that agree with the previous tick
                dout <= (same & s2) | (~same & dout);
            end
        end
    end

endmodule

// File: rtl/my_input_reader.sv
// CPU-readable debounced switches and buttons with
// write-1-to-clear button press events and an irq.
module my_input_reader
    import my_input_reader_pkg::*;
#(
    parameter int TICK_W = DEF_TICK_W,
    parameter int SW_N   = DEF_SW_N,
    parameter int BTN_N  = DEF_BTN_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_N-1:0]   sw_raw,
    input  logic [BTN_N-1:0]  btn_raw,
    input  logic [1:0]        sel,
    input  logic              re,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    logic [TICK_W-1:0] cnt;
    logic              tick;
    logic [SW_N-1:0]   sw_deb;
    logic [BTN_N-1:0]  btn_deb;
    logic [BTN_N-1:0]  btn_deb_q;
    logic [BTN_N-1:0]  evt;
    logic [BTN_N-1:0]  clr;
    logic [BTN_N-1:0]  rise;
    logic [31:0]       rd_mux;
    sel_e              sel_q;

    assign tick = &cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    my_debounce #(.N(SW_N)) u_sw (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .din  (sw_raw),
        .dout (sw_deb)
    );

    my_debounce #(.N(BTN_N)) u_btn (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .din  (btn_raw),
        .dout (btn_deb)
    );

    assign sel_q = sel_e'(sel);
    assign rise  = btn_deb & ~btn_deb_q;

    always_comb begin
        clr = '0;
        if (we && sel_q == SEL_EVT) begin
            clr = wdata[BTN_N-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (sel_q)
            SEL_SW:  rd_mux = 32'(sw_deb);
            SEL_BTN: rd_mux = 32'(btn_deb);
            SEL_EVT: rd_mux = 32'(evt);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_deb_q <= '0;
            evt       <= '0;
            irq       <= 1'b0;
            rdata     <= '0;
        end else begin
            btn_deb_q <= btn_deb;
            // a new press beats a simultaneous clear
            evt       <= (evt & ~clr) | rise;
            irq       <= |evt;
            if (re) begin
                rdata <= rd_mux;
            end
        end
    end

endmodule
